// File: rtl/mpu_engine.sv
// Parametrised matrix processor engine: instruction handshake, memory sequencing, ALU control.
// Optional MPU_ADDR_CHECK_EN rejects block instructions whose burst would run past the top address.
module mpu_engine #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned DIM    = 5,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 6,
    localparam int unsigned MAT_W = DIM * DIM * ELEM_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              alu_start,
    output logic [2:0]        alu_op,
    output logic [MAT_W-1:0]  alu_a,
    output logic [MAT_W-1:0]  alu_b,
    input  logic [MAT_W-1:0]  alu_c,
    input  logic              alu_done
);
    localparam int unsigned NWORDS = (MAT_W + WORD_W - 1) / WORD_W;
    localparam int unsigned REM    = MAT_W - (NWORDS - 1) * WORD_W;
    localparam int unsigned CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LastWord = CNT_W'(NWORDS - 1);

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpStore = 4'd1;
    localparam logic [3:0] OpLoad  = 4'd2;
    localparam logic [3:0] OpLda   = 4'd3;
    localparam logic [3:0] OpLdb   = 4'd4;

    typedef enum logic [2:0] {StIdle, StSingle, StSend, StBlkRd, StAluRun, StBlkWr} state_e;

    state_e             state_q;
    logic               mem_req_q, mem_we_q, out_valid_q, error_q, alu_start_q, sel_b_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [WORD_W-1:0]  mem_wdata_q, out_data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         alu_op_q;
    logic [MAT_W-1:0]   a_q, b_q, c_q, ld_mat;

    logic [3:0]         instr_op;
    logic [ADDR_W-1:0]  instr_addr;
    logic [WORD_W-1:0]  instr_data;
    logic               is_blk, blk_oob, unused_instr;

    assign instr_op     = instr_in[3:0];
    assign instr_addr   = instr_in[4 +: ADDR_W];
    assign instr_data   = instr_in[16 +: WORD_W];
    assign unused_instr = ^instr_in;
    assign is_blk       = (instr_op == OpLda) || (instr_op == OpLdb) || instr_op[3];

`ifdef MPU_ADDR_CHECK_EN
    assign blk_oob = (int'(instr_addr) + int'(NWORDS) - 1) > ((1 << ADDR_W) - 1);
`else
    assign blk_oob = 1'b0;
`endif

    // Last word of a block holds only REM matrix bits, left-justified in the memory word.
    function automatic logic [WORD_W-1:0] word_of(input logic [MAT_W-1:0] m,
                                                  input logic [CNT_W-1:0] k);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < NWORDS - 1; i++) begin
            if (k == CNT_W'(i)) w = m[i*WORD_W +: WORD_W];
        end
        if (k == LastWord) w[WORD_W-1 -: REM] = m[MAT_W-1 -: REM];
        return w;
    endfunction

    always_comb begin
        ld_mat = sel_b_q ? b_q : a_q;
        for (int unsigned i = 0; i < NWORDS - 1; i++) begin
            if (cnt_q == CNT_W'(i)) ld_mat[i*WORD_W +: WORD_W] = mem_rdata;
        end
        if (cnt_q == LastWord) ld_mat[MAT_W-1 -: REM] = mem_rdata[WORD_W-1 -: REM];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            alu_start_q <= 1'b0;
            alu_op_q    <= '0;
            sel_b_q     <= 1'b0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
        end else begin
            error_q     <= 1'b0;
            alu_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        mem_addr_q <= instr_addr;
                        cnt_q      <= '0;
                        sel_b_q    <= (instr_op == OpLdb);
                        if (instr_op == OpStore || instr_op == OpLoad) begin
                            state_q     <= StSingle;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= (instr_op == OpStore);
                            mem_wdata_q <= instr_data;
                        end else if (is_blk && blk_oob) begin
                            error_q <= 1'b1;
                        end else if (instr_op == OpLda || instr_op == OpLdb) begin
                            state_q   <= StBlkRd;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                        end else if (instr_op[3]) begin
                            state_q     <= StAluRun;
                            alu_start_q <= 1'b1;
                            alu_op_q    <= instr_op[2:0];
                        end else if (instr_op != OpNop) begin
                            error_q <= 1'b1;
                        end
                    end
                end
                StSingle: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!mem_we_q) begin
                            out_data_q  <= mem_rdata;
                            out_valid_q <= 1'b1;
                            state_q     <= StSend;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StSend: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                StBlkRd: begin
                    if (mem_ack) begin
                        if (sel_b_q) b_q <= ld_mat;
                        else         a_q <= ld_mat;
                        if (cnt_q == LastWord) begin
                            mem_req_q <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            cnt_q      <= cnt_q + 1'b1;
                            mem_addr_q <= mem_addr_q + 1'b1;
                        end
                    end
                end
                StAluRun: begin
                    if (alu_done) begin
                        c_q         <= alu_c;
                        state_q     <= StBlkWr;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= word_of(alu_c, '0);
                    end
                end
                StBlkWr: begin
                    if (mem_ack) begin
                        if (cnt_q == LastWord) begin
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            cnt_q       <= cnt_q + 1'b1;
                            mem_addr_q  <= mem_addr_q + 1'b1;
                            mem_wdata_q <= word_of(c_q, cnt_q + 1'b1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign error       = error_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign alu_start   = alu_start_q;
    assign alu_op      = alu_op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
endmodule

// File: doc/mpu_engine.md
Name: mpu_engine

Overview:
- Parametrised successor to the fixed 5x5 / 8-bit matrix processor top.
- Accepts 32-bit instructions over a valid/ready handshake and sequences single-word memory accesses, block loads of matrix A/B, ALU runs and block dumps of matrix C.
- Drives external memory and ALU through explicit request/acknowledge handshakes.
- Replaces edge-triggered instruction capture and combinational buffer muxing with one registered FSM.

Parameters:
ELEM_W, 8, bits per matrix element
DIM, 5, matrix is DIM x DIM
WORD_W, 16, memory word width; must be a multiple of ELEM_W and at most 16
ADDR_W, 6, memory address width; must be at most 12
Derived: MAT_W = DIM*DIM*ELEM_W. NWORDS = ceil(MAT_W/WORD_W). REM = MAT_W - (NWORDS-1)*WORD_W.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr_in  in  32  instruction word
instr_valid  in  1  instruction offered
instr_ready  out  1  engine idle, accepts instruction
out_data  out  WORD_W  LOAD result
out_valid  out  1  out_data valid
out_ready  in  1  consumer takes out_data
error  out  1  one-cycle pulse on rejected instruction
mem_req  out  1  memory access request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word address
mem_wdata  out  WORD_W  write data
mem_rdata  in  WORD_W  read data, valid when mem_ack is high
mem_ack  in  1  one-cycle completion of the current access
alu_start  out  1  one-cycle start pulse
alu_op  out  3  ALU operation
alu_a  out  MAT_W  matrix A register
alu_b  out  MAT_W  matrix B register
alu_c  in  MAT_W  ALU result, sampled when alu_done is high
alu_done  in  1  ALU completion pulse

Behaviour:
- Instruction fields: op=[3:0], addr=[4+ADDR_W-1:4], data=[31:16] (low WORD_W bits used).
- Opcodes:
  - 0 NOP.
  - 1 STORE: write data to addr.
  - 2 LOAD: read addr and return it on out_data.
  - 3 LDA / 4 LDB: block read of NWORDS words from base addr into A or B.
  - 8-15 ALU: alu_op=op[2:0]; run the ALU, then block-write C to base addr.
  - 5-7 illegal: error pulses the cycle after accept; state stays IDLE.
- Reset (async, any state): FSM to IDLE; A, B and C registers cleared. instr_ready=1. All other outputs 0.
- instr_ready=1 only in IDLE. The instruction is captured on instr_valid&&instr_ready. The FSM leaves IDLE on the next edge. NOP keeps the FSM in IDLE.
- FSM states:
  - IDLE.
  - SINGLE: mem_req held with fixed addr/we/wdata until mem_ack. A STORE ack goes to IDLE. A LOAD ack captures mem_rdata into out_data and goes to SEND.
  - SEND: out_valid=1 with out_data stable until out_ready, then IDLE. out_ready already high on entry completes in that cycle.
  - BLK_RD: word counter k runs 0..NWORDS-1; mem_addr = base+k.
  - ALU_RUN: alu_start pulses exactly one cycle on entry, then the FSM waits for alu_done and latches alu_c into C.
  - BLK_WR: same counter; mem_we=1, writing C.
  - Block states return to IDLE after the ack for k=NWORDS-1.
- Burst timing: mem_req stays high across a block. addr and wdata advance on the edge after each ack.
- Packing: word k maps to matrix bits [k*WORD_W +: WORD_W].
  - Last word when REM<WORD_W: the load takes mem_rdata[WORD_W-1 -: REM]. The dump sends {C top REM bits, zeros}.
- Address arithmetic is modulo 2^ADDR_W (wraps) unless ADDR_CHECK is enabled.
- alu_a and alu_b are driven directly from registers and stay stable outside LDA/LDB.
- out_data keeps its last value after SEND. out_valid drops on the edge after the handshake.
- mem_ack outside a request is ignored. alu_done outside ALU_RUN is ignored.

Optional Feature:
- Macro MPU_ADDR_CHECK_EN.
- Defined: a block instruction with base+NWORDS-1 > 2^ADDR_W-1 is rejected. error pulses, no mem_req is issued, no ALU start, state stays IDLE.
- Undefined: the block address wraps to 0 and no error is raised.

Test Plan:
All scenarios use defaults: MAT_W=200, NWORDS=13, REM=8.
- Reset asserted mid-BLK_RD (k=6) -> same cycle: mem_req=0, instr_ready=1, alu_a=0.
- STORE addr=5 data=0xBEEF, mem_ack after 2 cycles -> mem_req/mem_we high with addr 5, wdata 0xBEEF until ack; instr_ready=1 one cycle later.
- LOAD addr=5, memory returns 0xBEEF, out_ready low 3 cycles -> out_valid high, out_data=0xBEEF held, drops after handshake.
- LDA base=0, memory word k = 0x1100+k, ack every cycle -> 13 reads at addresses 0..12; alu_a[15:0]=0x1100; alu_a[199:192]=0x11.
- ALU op 9 base=20, alu_done 4 cycles after start -> one-cycle alu_start with alu_op=1; 13 writes to addresses 20..32; last mem_wdata={C[199:192],8'h00}.
- LDB base=60 -> without macro: addresses 60..63 then 0..8. With macro: error pulse, no mem_req. Opcode 6 -> error pulse, FSM stays IDLE.
